// File: rtl/layernorm_seq_ctrl_if.sv
// Command, SRAM and engine signal bundle around the layernorm sequencer.
// master = sequencer side, slave = decoder / SRAM / engine side.
interface layernorm_seq_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_W      = 6,
  parameter int ROW_W      = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_src;
  logic [ADDR_WIDTH-1:0] cmd_dst;
  logic [ADDR_WIDTH-1:0] cmd_param;
  logic [DIM_W-1:0]      cmd_dim;
  logic [ROW_W-1:0]      cmd_rows;
  logic                  done;
  logic                  err;

  logic                  act_rd_en;
  logic [ADDR_WIDTH-1:0] act_rd_addr;
  logic [DATA_WIDTH-1:0] act_rd_data;
  logic                  act_wr_en;
  logic [ADDR_WIDTH-1:0] act_wr_addr;
  logic [DATA_WIDTH-1:0] act_wr_data;

  logic                  par_rd_en;
  logic [ADDR_WIDTH-1:0] par_rd_addr;
  logic [DATA_WIDTH-1:0] par_gamma;
  logic [DATA_WIDTH-1:0] par_beta;

  logic                  eng_start;
  logic                  eng_data_valid;
  logic                  eng_param_valid;
  logic [DIM_W-1:0]      eng_hidden_dim;
  logic [DATA_WIDTH-1:0] eng_data_in;
  logic [DATA_WIDTH-1:0] eng_gamma;
  logic [DATA_WIDTH-1:0] eng_beta;
  logic                  eng_busy;
  logic                  eng_done;
  logic                  eng_out_valid;
  logic [DATA_WIDTH-1:0] eng_data_out;

  modport master (
    input  cmd_valid, cmd_src, cmd_dst, cmd_param, cmd_dim, cmd_rows,
    output cmd_ready, done, err,
    output act_rd_en, act_rd_addr, act_wr_en, act_wr_addr, act_wr_data,
    input  act_rd_data,
    output par_rd_en, par_rd_addr,
    input  par_gamma, par_beta,
    output eng_start, eng_data_valid, eng_param_valid, eng_hidden_dim,
    output eng_data_in, eng_gamma, eng_beta,
    input  eng_busy, eng_done, eng_out_valid, eng_data_out
  );

  modport slave (
    output cmd_valid, cmd_src, cmd_dst, cmd_param, cmd_dim, cmd_rows,
    input  cmd_ready, done, err,
    input  act_rd_en, act_rd_addr, act_wr_en, act_wr_addr, act_wr_data,
    output act_rd_data,
    input  par_rd_en, par_rd_addr,
    output par_gamma, par_beta,
    input  eng_start, eng_data_valid, eng_param_valid, eng_hidden_dim,
    input  eng_data_in, eng_gamma, eng_beta,
    output eng_busy, eng_done, eng_out_valid, eng_data_out
  );
endinterface

// File: rtl/layernorm_seq_ctrl.sv
// Command-level sequencer for the INT8 layernorm engine: param load, per-row feed and write-back.
// Optional LN_SEQ_PERF_EN adds a saturating busy-cycle counter on port perf_cycles.
module layernorm_seq_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int MAX_HIDDEN_DIM = 64,
  parameter int ROW_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  layernorm_seq_ctrl_if.master bus
`ifdef LN_SEQ_PERF_EN
  ,
  output logic [31:0]          perf_cycles
`endif
);
  localparam int DIM_W = $clog2(MAX_HIDDEN_DIM);

  typedef enum logic [2:0] {IDLE, LOAD_PARAM, START, FEED, DRAIN, NEXT, FIN} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] row_src_reg, row_dst_reg, par_addr_reg, rd_addr_reg, wr_addr_reg;
  logic [DIM_W-1:0]      dim_reg, rd_cnt_reg;
  logic [DIM_W:0]        wcnt_reg;
  logic [ROW_W-1:0]      rows_reg, row_cnt_reg;
  logic [DATA_WIDTH-1:0] wr_data_reg;
  logic                  par_rd_en_reg, act_rd_en_reg, param_valid_reg, data_valid_reg;
  logic                  eng_start_reg, done_reg, err_reg, done_seen_reg, act_wr_en_reg;

  logic                  cmd_ready;
  logic                  accept;
  logic                  row_end;
  logic [ROW_W-1:0]      row_cnt_inc;

  assign cmd_ready   = (state_reg == IDLE) && !bus.eng_busy;
  assign accept      = bus.cmd_valid && cmd_ready;
  assign row_end     = (done_seen_reg || bus.eng_done) && !bus.eng_busy && !bus.eng_out_valid;
  assign row_cnt_inc = row_cnt_reg + ROW_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      row_src_reg     <= '0;
      row_dst_reg     <= '0;
      par_addr_reg    <= '0;
      rd_addr_reg     <= '0;
      wr_addr_reg     <= '0;
      dim_reg         <= '0;
      rd_cnt_reg      <= '0;
      wcnt_reg        <= '0;
      rows_reg        <= '0;
      row_cnt_reg     <= '0;
      wr_data_reg     <= '0;
      par_rd_en_reg   <= 1'b0;
      act_rd_en_reg   <= 1'b0;
      param_valid_reg <= 1'b0;
      data_valid_reg  <= 1'b0;
      eng_start_reg   <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      done_seen_reg   <= 1'b0;
      act_wr_en_reg   <= 1'b0;
    end else begin
      eng_start_reg   <= 1'b0;
      done_reg        <= 1'b0;
      act_wr_en_reg   <= 1'b0;
      // SRAM data returns one cycle after the read, so valid is simply the delayed enable
      param_valid_reg <= par_rd_en_reg;
      data_valid_reg  <= act_rd_en_reg;

      case (state_reg)
        IDLE: begin
          if (accept) begin
            dim_reg     <= bus.cmd_dim;
            rows_reg    <= bus.cmd_rows;
            row_src_reg <= bus.cmd_src;
            row_dst_reg <= bus.cmd_dst;
            row_cnt_reg <= '0;
            err_reg     <= 1'b0;
            if (bus.cmd_dim == '0 || bus.cmd_rows == '0) begin
              err_reg   <= 1'b1;
              state_reg <= FIN;
            end else begin
              par_rd_en_reg <= 1'b1;
              par_addr_reg  <= bus.cmd_param;
              rd_cnt_reg    <= DIM_W'(1);
              state_reg     <= LOAD_PARAM;
            end
          end
        end

        LOAD_PARAM: begin
          if (rd_cnt_reg != dim_reg) begin
            par_rd_en_reg <= 1'b1;
            par_addr_reg  <= par_addr_reg + ADDR_WIDTH'(1);
            rd_cnt_reg    <= rd_cnt_reg + DIM_W'(1);
          end else begin
            par_rd_en_reg <= 1'b0;
            // Enable already low means this cycle carries the last return beat
            if (!par_rd_en_reg) begin
              state_reg     <= START;
              eng_start_reg <= 1'b1;
              act_rd_en_reg <= 1'b1;
              rd_addr_reg   <= row_src_reg;
              rd_cnt_reg    <= DIM_W'(1);
              wcnt_reg      <= '0;
              done_seen_reg <= 1'b0;
            end
          end
        end

        START, FEED: begin
          done_seen_reg <= done_seen_reg || bus.eng_done;
          if (rd_cnt_reg != dim_reg) begin
            act_rd_en_reg <= 1'b1;
            rd_addr_reg   <= rd_addr_reg + ADDR_WIDTH'(1);
            rd_cnt_reg    <= rd_cnt_reg + DIM_W'(1);
          end else begin
            act_rd_en_reg <= 1'b0;
          end
          if (state_reg == START) begin
            state_reg <= FEED;
          end else if (!act_rd_en_reg) begin
            state_reg <= DRAIN;
          end
        end

        DRAIN: begin
          done_seen_reg <= done_seen_reg || bus.eng_done;
          if (bus.eng_out_valid) begin
            act_wr_en_reg <= 1'b1;
            wr_addr_reg   <= row_dst_reg + ADDR_WIDTH'(wcnt_reg);
            wr_data_reg   <= bus.eng_data_out;
            wcnt_reg      <= wcnt_reg + (DIM_W+1)'(1);
          end else if (row_end) begin
            if (wcnt_reg != {1'b0, dim_reg}) begin
              err_reg <= 1'b1;
            end
            state_reg <= NEXT;
          end
        end

        NEXT: begin
          row_src_reg <= row_src_reg + ADDR_WIDTH'(dim_reg);
          row_dst_reg <= row_dst_reg + ADDR_WIDTH'(dim_reg);
          row_cnt_reg <= row_cnt_inc;
          if (row_cnt_inc == rows_reg) begin
            state_reg <= FIN;
          end else begin
            state_reg     <= START;
            eng_start_reg <= 1'b1;
            act_rd_en_reg <= 1'b1;
            rd_addr_reg   <= row_src_reg + ADDR_WIDTH'(dim_reg);
            rd_cnt_reg    <= DIM_W'(1);
            wcnt_reg      <= '0;
            done_seen_reg <= 1'b0;
          end
        end

        FIN: begin
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef LN_SEQ_PERF_EN
  logic [31:0] perf_cycles_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_reg <= '0;
    end else if (accept) begin
      perf_cycles_reg <= '0;
    end else if (state_reg != IDLE && perf_cycles_reg != 32'hFFFF_FFFF) begin
      perf_cycles_reg <= perf_cycles_reg + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_reg;
`endif

  assign bus.cmd_ready       = cmd_ready;
  assign bus.done            = done_reg;
  assign bus.err             = err_reg;
  assign bus.act_rd_en       = act_rd_en_reg;
  assign bus.act_rd_addr     = rd_addr_reg;
  assign bus.act_wr_en       = act_wr_en_reg;
  assign bus.act_wr_addr     = wr_addr_reg;
  assign bus.act_wr_data     = wr_data_reg;
  assign bus.par_rd_en       = par_rd_en_reg;
  assign bus.par_rd_addr     = par_addr_reg;
  assign bus.eng_start       = eng_start_reg;
  assign bus.eng_data_valid  = data_valid_reg;
  assign bus.eng_param_valid = param_valid_reg;
  assign bus.eng_hidden_dim  = dim_reg;
  assign bus.eng_data_in     = data_valid_reg  ? bus.act_rd_data : '0;
  assign bus.eng_gamma       = param_valid_reg ? bus.par_gamma   : '0;
  assign bus.eng_beta        = param_valid_reg ? bus.par_beta    : '0;
endmodule

// File: tb/tb_layernorm_seq_ctrl.sv
// Directed and randomized bench for layernorm_seq_ctrl with SRAM/engine models and a command-level reference.
`timescale 1ns/1ps
module tb_layernorm_seq_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int MAXD  = 64;
  localparam int RW    = 8;
  localparam int DIM_W = $clog2(MAXD);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layernorm_seq_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIM_W(DIM_W), .ROW_W(RW)) bus ();

`ifdef LN_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  layernorm_seq_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_HIDDEN_DIM(MAXD), .ROW_W(RW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef LN_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // SRAM models: activation memory is random; parameters are a fixed function of address
  logic [7:0] mem [0:65535];

  function automatic logic [7:0] gam(input logic [15:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] bet(input logic [15:0] a);
    return a[15:8] + a[7:0] + 8'd3;
  endfunction

  always @(posedge clk) begin
    if (bus.par_rd_en) begin
      bus.par_gamma <= gam(bus.par_rd_addr);
      bus.par_beta  <= bet(bus.par_rd_addr);
    end
    if (bus.act_rd_en) bus.act_rd_data <= mem[bus.act_rd_addr];
  end

  // Engine model: collects N inputs, returns out_beats results of input+1, then pulses done
  int         out_beats = 0;
  int         e_phase = 0;
  int         e_k = 0;
  logic [7:0] e_in[$];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.eng_busy      = 1'b0;
      bus.eng_out_valid = 1'b0;
      bus.eng_done      = 1'b0;
      bus.eng_data_out  = 8'd0;
      e_phase           = 0;
      e_k               = 0;
      e_in.delete();
    end else begin
      case (e_phase)
        0: begin
          bus.eng_done = 1'b0;
          if (bus.eng_start) begin
            bus.eng_busy = 1'b1;
            e_in.delete();
            e_phase = 1;
          end
        end
        1: begin
          if (bus.eng_data_valid) e_in.push_back(bus.eng_data_in);
          if (e_in.size() == int'(bus.eng_hidden_dim)) begin
            e_phase = 2;
            e_k     = 0;
          end
        end
        default: begin
          if (e_k < out_beats) begin
            bus.eng_out_valid = 1'b1;
            bus.eng_data_out  = e_in[e_k] + 8'd1;
            e_k++;
          end else begin
            bus.eng_out_valid = 1'b0;
            bus.eng_done      = 1'b1;
            bus.eng_busy      = 1'b0;
            e_phase           = 0;
          end
        end
      endcase
    end
  end

  // Monitor: cycle-stamped record of everything the sequencer drives
  int          cyc = 0;
  logic [15:0] m_par[$];
  int          m_par_cyc[$];
  int          m_prd[$];
  logic [15:0] m_rd[$];
  logic [7:0]  m_din[$];
  int          m_din_cyc[$];
  int          m_start[$];
  logic [23:0] m_wr[$];
  int          m_done[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.eng_param_valid) begin
        m_par.push_back({bus.eng_gamma, bus.eng_beta});
        m_par_cyc.push_back(cyc);
      end
      if (bus.par_rd_en) m_prd.push_back(cyc);
      if (bus.act_rd_en) m_rd.push_back(bus.act_rd_addr);
      if (bus.eng_data_valid) begin
        m_din.push_back(bus.eng_data_in);
        m_din_cyc.push_back(cyc);
      end
      if (bus.eng_start) m_start.push_back(cyc);
      if (bus.act_wr_en) m_wr.push_back({bus.act_wr_addr, bus.act_wr_data});
      if (bus.done) m_done.push_back(cyc);
    end
  end

  task automatic clear_mon();
    m_par.delete(); m_par_cyc.delete(); m_prd.delete(); m_rd.delete();
    m_din.delete(); m_din_cyc.delete(); m_start.delete(); m_wr.delete(); m_done.delete();
  endtask

  task automatic drive_cmd(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] prm,
                           input int dim, input int rows, output int c0);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    bus.cmd_param = prm;
    bus.cmd_dim   = DIM_W'(dim);
    bus.cmd_rows  = RW'(rows);
    c0 = cyc;
  endtask

  task automatic run_cmd(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] prm,
                         input int dim, input int rows, input int beats);
    int          c0;
    int          t;
    int          k;
    logic        exp_err;
    logic [15:0] a;
    logic [7:0]  ed;
    exp_err   = (dim == 0 || rows == 0) ? 1'b1 : (beats != dim);
    out_beats = beats;
    clear_mon();
    drive_cmd(src, dst, prm, dim, rows, c0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    t = 0;
    while (m_done.size() == 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("done_cnt", m_done.size(), 1);
    check("err", bus.err, exp_err);
    if (dim == 0 || rows == 0) begin
      if (m_done.size() > 0) check("illegal_latency", m_done[0] - c0, 2);
      check("illegal_activity", m_prd.size() + m_rd.size() + m_start.size() + m_wr.size() + m_par.size(), 0);
    end else begin
      check("par_cnt", m_par.size(), dim);
      for (int i = 0; i < dim && i < m_par.size(); i++) begin
        a = prm + 16'(i);
        check("par_data", m_par[i], {gam(a), bet(a)});
        check("par_cyc", m_par_cyc[i] - c0, i + 2);
      end
      check("start_cnt", m_start.size(), rows);
      if (m_start.size() > 0) check("start0_cyc", m_start[0] - c0, dim + 2);
      check("rd_cnt", m_rd.size(), rows * dim);
      check("din_cnt", m_din.size(), rows * dim);
      for (int r = 0; r < rows; r++) begin
        for (int i = 0; i < dim; i++) begin
          k = r * dim + i;
          a = src + 16'(k);
          if (k < m_rd.size()) check("rd_addr", m_rd[k], a);
          if (k < m_din.size()) check("din_data", m_din[k], mem[a]);
          if (k < m_din.size() && r < m_start.size()) check("din_cyc", m_din_cyc[k] - m_start[r], i + 1);
        end
      end
      check("wr_cnt", m_wr.size(), rows * beats);
      for (int r = 0; r < rows; r++) begin
        for (int i = 0; i < beats; i++) begin
          k  = r * beats + i;
          a  = src + 16'(r * dim + i);
          ed = mem[a] + 8'd1;
          if (k < m_wr.size()) check("wr_beat", m_wr[k], {dst + 16'(r * dim + i), ed});
        end
      end
    end
    $display("cmd src=%h dst=%h par=%h N=%0d R=%0d beats=%0d err=%0b done=%0d",
             src, dst, prm, dim, rows, beats, bus.err, m_done.size());
  endtask

  initial begin
    int c0;
    int t;
    int dim;
    int rows;
    int beats;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    bus.cmd_valid = 1'b0;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;
    bus.cmd_param = '0;
    bus.cmd_dim   = '0;
    bus.cmd_rows  = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_rd_en", {bus.act_rd_en, bus.par_rd_en, bus.act_wr_en}, 0);
    check("rst_eng_ctl", {bus.eng_start, bus.eng_data_valid, bus.eng_param_valid}, 0);
    check("rst_hidden_dim", bus.eng_hidden_dim, 0);

    run_cmd(16'h0010, 16'h0040, 16'h0080, 4, 1, 4);
    run_cmd(16'h0000, 16'h0100, 16'h0200, 8, 3, 8);
    run_cmd(16'h0020, 16'h0060, 16'h0090, 0, 2, 0);
    run_cmd(16'h0020, 16'h0060, 16'h0090, 5, 0, 0);
    run_cmd(16'h0030, 16'h0070, 16'h00A0, 4, 1, 1);
    run_cmd(16'hFFFE, 16'hFFFD, 16'hFFFF, 4, 1, 4);
    run_cmd(16'h0123, 16'h0456, 16'h0789, 1, 2, 1);

    // A command held valid across FIN is taken on the first IDLE cycle afterwards
    clear_mon();
    drive_cmd(16'h0, 16'h0, 16'h0, 0, 1, c0);
    @(negedge clk);
    check("held_ready_fin", bus.cmd_ready, 0);
    @(negedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("held_done_cnt", m_done.size(), 2);
    if (m_done.size() == 2) check("held_done2_cyc", m_done[1] - c0, 4);
    check("held_err", bus.err, 1);
    $display("cmd held-valid illegal x2 done=%0d err=%0b", m_done.size(), bus.err);

    // Asynchronous reset in the middle of row 2 of 3
    clear_mon();
    out_beats = 8;
    drive_cmd(16'h0300, 16'h0400, 16'h0500, 8, 3, c0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    t = 0;
    while (!(m_start.size() >= 2 && m_din.size() >= 11) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("reset_reached_row2", (m_start.size() >= 2 && m_din.size() >= 11), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_ready", bus.cmd_ready, 1);
    check("areset_sram", {bus.act_rd_en, bus.par_rd_en, bus.act_wr_en}, 0);
    check("areset_eng", {bus.eng_start, bus.eng_data_valid, bus.eng_param_valid}, 0);
    check("areset_done_err", {bus.done, bus.err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("areset_no_done", m_done.size(), 0);
    check("areset_idle_ready", bus.cmd_ready, 1);
    $display("cmd reset mid-FEED row2 starts=%0d beats=%0d", m_start.size(), m_din.size());
    run_cmd(16'h0600, 16'h0700, 16'h0800, 6, 2, 6);

    for (int n = 0; n < 10; n++) begin
      dim   = $urandom_range(1, 12);
      rows  = $urandom_range(1, 4);
      beats = ($urandom_range(0, 3) == 0) ? $urandom_range(1, dim) : dim;
      run_cmd(16'($urandom), 16'($urandom), 16'($urandom), dim, rows, beats);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/layernorm_seq_ctrl.md
# layernorm_seq_ctrl

Command-level sequencer for the INT8 layer-normalization engine. It accepts one command describing a block of rows, loads gamma/beta from the parameter SRAM into the engine, and for each row starts the engine and streams the row in from the activation SRAM. It then captures the engine's output beats and writes them back to the destination region. It sits between the NPU instruction decoder and the layernorm engine and owns all engine control pins.

## Interface
Parameters:
- DATA_WIDTH, 8, element width
- ADDR_WIDTH, 16, SRAM word address width
- MAX_HIDDEN_DIM, 64, engine buffer depth; DIM_W = $clog2(MAX_HIDDEN_DIM)
- ROW_W, 8, row-count width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid / cmd_ready  in/out  1  command handshake; accepted when both high on a clk edge
- cmd_src, cmd_dst  in  ADDR_WIDTH  first-row source / destination addresses
- cmd_param  in  ADDR_WIDTH  parameter SRAM base address
- cmd_dim  in  DIM_W  hidden dimension N, legal 1..MAX_HIDDEN_DIM-1
- cmd_rows  in  ROW_W  row count R, legal ≥1
- done  out  1  one-cycle pulse at command completion
- err  out  1  sticky until next accepted command; set on illegal command or short row
- act_rd_en / act_rd_addr / act_rd_data  out/out/in  1/ADDR_WIDTH/DATA_WIDTH  activation read; data valid exactly 1 cycle after rd_en
- act_wr_en / act_wr_addr / act_wr_data  out  1/ADDR_WIDTH/DATA_WIDTH  activation write
- par_rd_en / par_rd_addr  out  1/ADDR_WIDTH  parameter read, 1-cycle latency
- par_gamma / par_beta  in  DATA_WIDTH  returned gamma and beta for the same address
- eng_start, eng_data_valid, eng_param_valid  out  1  engine controls
- eng_hidden_dim  out  DIM_W  registered copy of cmd_dim
- eng_data_in, eng_gamma, eng_beta  out  DATA_WIDTH  engine data
- eng_busy, eng_done, eng_out_valid  in  1  engine status
- eng_data_out  in  DATA_WIDTH  engine result

## Operation
- States: IDLE, LOAD_PARAM, START, FEED, DRAIN, NEXT, FIN.
- **IDLE:** cmd_ready=1. On accept, latch all fields and clear err.
  - If N==0 or R==0: set err and go to FIN.
  - Otherwise go to LOAD_PARAM. When eng_busy=1, cmd_ready=0.
- **LOAD_PARAM:** issue N reads at cmd_param+i, i=0..N-1, one per cycle. Returned data drives eng_gamma/eng_beta with eng_param_valid one cycle later. After the last return beat, go to START. Parameters load once per command, because the engine buffer persists across rows.
- **START:** pulse eng_start for one cycle. In the same cycle issue the first act read at row_src+0. Go to FEED.
- **FEED:** continue reads at row_src+i until N reads are issued. eng_data_valid/eng_data_in are the rd_en/rd_data delayed by one cycle. After the last beat, go to DRAIN.
- **DRAIN:**
  - Each eng_out_valid beat produces act_wr_en=1, act_wr_addr=row_dst+wcnt, act_wr_data=eng_data_out, and wcnt++.
  - The row ends on the first cycle with eng_done seen (latched), eng_busy=0 and eng_out_valid=0.
  - If wcnt≠N at row end, set err. The row still counts as complete.
- **NEXT:** row_src += N, row_dst += N (adders, no multiplier), row++.
  - If row==R, go to FIN. Otherwise go to START.
- **FIN:** pulse done, return to IDLE.
- Address arithmetic wraps modulo 2^ADDR_WIDTH, with no error flagged.
- Engine outputs arriving outside DRAIN are ignored and never written.

## Timing
- Reset values: all outputs 0 except cmd_ready=1. Counters and err are 0.
- Reset asserted mid-command returns to IDLE asynchronously. Writes stop immediately. No done pulse.
- LOAD_PARAM takes N+1 cycles.
- FEED: the first engine data beat arrives 1 cycle after eng_start, and N beats are sent on consecutive cycles.
- Per-row overhead outside the engine: START 1 cycle + NEXT 1 cycle.
- Command latency (illegal command): accept → done = 2 cycles.
- cmd_valid held high while busy is not accepted. The held command is accepted on the IDLE cycle after FIN.

## Configuration
- LN_SEQ_PERF_EN defined:
  - adds output port perf_cycles [31:0], counting cycles spent outside IDLE for the last command.
  - The counter clears on accept, holds after done, and saturates at 0xFFFFFFFF.
- LN_SEQ_PERF_EN undefined: the port and counter are absent. Behaviour is otherwise identical.

## Test plan
- N=4, R=1, src=0x10, dst=0x40, param=0x80:
  - 4 param beats, then eng_start, then eng_data_valid on 4 consecutive cycles with data from 0x10..0x13.
  - Engine model returns 4 beats, written to 0x40..0x43. done pulses once; err=0.
- N=8, R=3: sources 0x00/0x08/0x10 are read in order and destinations are advanced by 8 per row. Exactly 3 eng_start pulses and 1 param load.
- cmd_dim=0 → err=1, done 2 cycles after accept, no engine or SRAM activity.
- Engine model emits only 1 output beat for N=4 → err=1, 1 write, command completes and done pulses.
- Reset asserted during FEED of row 2 of 3 → all outputs 0 and cmd_ready=1 next cycle. A new command then runs cleanly.
- src=0xFFFE, N=4 → reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
